fir_xifu_mem_req: RTL and testbench
===================================

FIR_XIFU_MEM_REQ -- requirements
Module: fir_xifu_mem_req

Parameters
REQ-001 SHALL have parameter DEPTH, default 2: maximum outstanding memory transactions (power of two, 1..8).
REQ-002 SHALL have parameter IDW, default 4: X-interface instruction id width.

Interface
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 issue_valid_i  in  1  EX stage presents a sample load/store.
REQ-006 issue_ready_o  out  1  block accepts the issue this cycle.
REQ-007 issue_id_i  in  IDW  X-interface instruction id.
REQ-008 issue_we_i  in  1  1 = store sample, 0 = load sample.
REQ-009 issue_addr_i / issue_wdata_i / issue_next_addr_i  in  32 each  access address, store data, post-incremented base address.
REQ-010 issue_rd_i  in  5  register receiving next_addr.
REQ-011 mem_valid_o  out  1  memory request valid.
REQ-012 mem_ready_i  in  1  core accepts the request.
REQ-013 mem_id_o  out  IDW; mem_addr_o  out  32; mem_wdata_o  out  32; mem_we_o  out  1; mem_be_o  out  4  request payload.
REQ-014 mem_resp_exc_i  in  1  core response to the accepted request: access faulted.
REQ-015 mem_result_valid_i  in  1; mem_result_id_i  in  IDW  memory result returned by core.
REQ-016 ex2wb_valid_o  out  1; ex2wb_id_o  out  IDW; ex2wb_rd_o  out  5; ex2wb_next_addr_o  out  32; ex2wb_we_o  out  1  transaction context handed to writeback.
REQ-017 exc_o  out  1  one-cycle pulse: request faulted.
REQ-018 err_o  out  1  sticky: protocol violation detected.

Function
REQ-019 SHALL implement FSM IDLE/REQ; IDLE -> REQ on issue handshake; REQ -> IDLE on mem_valid_o & mem_ready_i.
REQ-020 issue_ready_o SHALL be 1 only in IDLE with outstanding count < DEPTH.
REQ-021 On issue handshake SHALL latch id, we, addr, wdata, rd, next_addr; mem_valid_o SHALL rise the following cycle (latency 1).
REQ-022 In REQ mem_valid_o SHALL stay 1 and all mem_* payload SHALL stay stable until mem_ready_i.
REQ-023 mem_be_o SHALL be 4'b1111; mem_we_o SHALL equal latched we.
REQ-024 On mem handshake with mem_resp_exc_i=0 SHALL push {id, rd, next_addr, we} into a DEPTH-entry FIFO.
REQ-025 On mem handshake with mem_resp_exc_i=1 SHALL not push and SHALL pulse exc_o for the following cycle.
REQ-026 ex2wb_* SHALL be combinational from FIFO head; ex2wb_valid_o = mem_result_valid_i & FIFO non-empty & head id == mem_result_id_i.
REQ-027 On mem_result_valid_i with valid match SHALL pop the head the same cycle.
REQ-028 mem_result_valid_i with FIFO empty or id mismatch SHALL set err_o, SHALL not pop, ex2wb_valid_o = 0.
REQ-029 Simultaneous push and pop SHALL leave count unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-030 Simultaneous push and pop at count = DEPTH is impossible by REQ-020; at count = 0 the pop SHALL be rejected per REQ-028 (no bypass).
REQ-031 When ex2wb_valid_o = 0, ex2wb_id_o/rd/next_addr/we SHALL still show head contents (don't-care to consumers).

Reset
REQ-032 rst_i SHALL asynchronously force IDLE, empty FIFO, count 0, err_o 0, exc_o 0, mem_valid_o 0, issue_ready_o 1 (combinational from reset state), mem_* payload 0.
REQ-033 Reset mid-transaction SHALL drop pending request and all outstanding entries; no ex2wb_valid_o after release without new traffic.

Verification
REQ-034 Load id=3, addr=0x100, next_addr=0x104, rd=5, mem_ready_i=1 immediately; result id=3 two cycles later -> mem_valid_o one cycle, ex2wb_valid_o=1 with rd=5, next_addr=0x104, we=0.
REQ-035 Store wdata=0xDEADBEEF, mem_ready_i low 3 cycles -> mem_valid_o held 4 cycles, payload constant, issue_ready_o=0 throughout.
REQ-036 DEPTH=2: two accepted requests, no results -> issue_ready_o=0; result for first id -> issue_ready_o=1 next cycle, ex2wb shows first context.
REQ-037 Handshake with mem_resp_exc_i=1 -> exc_o one-cycle pulse, count unchanged, later result for that id sets err_o.
REQ-038 mem_result_valid_i with empty FIFO -> err_o=1 sticky; rst_i pulse -> err_o=0.
REQ-039 Assert rst_i while mem_valid_o=1 with one outstanding -> mem_valid_o=0 immediately, count 0, issue_ready_o=1.

Source files
------------

// File: rtl/fir_xifu_mem_req.sv
// fir_xifu_mem_req: issues FIR sample loads/stores to the core memory port and
// tracks outstanding transactions until their results come back.
module fir_xifu_mem_req #(
    parameter int DEPTH = 2,
    parameter int IDW   = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           issue_valid_i,
    output logic           issue_ready_o,
    input  logic [IDW-1:0] issue_id_i,
    input  logic           issue_we_i,
    input  logic [31:0]    issue_addr_i,
    input  logic [31:0]    issue_wdata_i,
    input  logic [31:0]    issue_next_addr_i,
    input  logic [4:0]     issue_rd_i,
    output logic           mem_valid_o,
    input  logic           mem_ready_i,
    output logic [IDW-1:0] mem_id_o,
    output logic [31:0]    mem_addr_o,
    output logic [31:0]    mem_wdata_o,
    output logic           mem_we_o,
    output logic [3:0]     mem_be_o,
    input  logic           mem_resp_exc_i,
    input  logic           mem_result_valid_i,
    input  logic [IDW-1:0] mem_result_id_i,
    output logic           ex2wb_valid_o,
    output logic [IDW-1:0] ex2wb_id_o,
    output logic [4:0]     ex2wb_rd_o,
    output logic [31:0]    ex2wb_next_addr_o,
    output logic           ex2wb_we_o,
    output logic           exc_o,
    output logic           err_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_nxt;

    logic [IDW-1:0] fifo_id [DEPTH];
    logic [4:0]     fifo_rd [DEPTH];
    logic [31:0]    fifo_na [DEPTH];
    logic           fifo_we [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [4:0]     rd_l;
    logic [31:0]    na_l;
    logic           issue_hs, mem_hs, push, pop;

    assign issue_ready_o = state == IDLE && count < CW'(DEPTH);
    assign mem_valid_o   = state == REQ;
    assign mem_be_o      = 4'b1111;
    assign issue_hs      = issue_valid_i && issue_ready_o;
    assign mem_hs        = mem_valid_o && mem_ready_i;
    assign push          = mem_hs && !mem_resp_exc_i;
    // A result is only consumed when it names the oldest outstanding access.
    assign pop           = mem_result_valid_i && count != '0 && fifo_id[rd_ptr] == mem_result_id_i;

    assign ex2wb_valid_o     = pop;
    assign ex2wb_id_o        = fifo_id[rd_ptr];
    assign ex2wb_rd_o        = fifo_rd[rd_ptr];
    assign ex2wb_next_addr_o = fifo_na[rd_ptr];
    assign ex2wb_we_o        = fifo_we[rd_ptr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue_hs) state_nxt = REQ;
            REQ:     if (mem_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mem_id_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= 1'b0;
            rd_l        <= '0;
            na_l        <= '0;
            exc_o       <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue_hs) begin
                mem_id_o    <= issue_id_i;
                mem_addr_o  <= issue_addr_i;
                mem_wdata_o <= issue_wdata_i;
                mem_we_o    <= issue_we_i;
                rd_l        <= issue_rd_i;
                na_l        <= issue_next_addr_i;
            end
            exc_o <= mem_hs && mem_resp_exc_i;
            err_o <= err_o || (mem_result_valid_i && !pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_id[i] <= '0;
                fifo_rd[i] <= '0;
                fifo_na[i] <= '0;
                fifo_we[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_id[wr_ptr] <= mem_id_o;
                fifo_rd[wr_ptr] <= rd_l;
                fifo_na[wr_ptr] <= na_l;
                fifo_we[wr_ptr] <= mem_we_o;
                wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fir_xifu_mem_req.sv
// tb_fir_xifu_mem_req: cycle-by-cycle vector table for fir_xifu_mem_req with
// a hand-written asynchronous reset sequence.
module tb_fir_xifu_mem_req;
    logic        clk_i = 0, rst_i = 1;
    logic        issue_valid_i = 0, issue_ready_o, issue_we_i = 0;
    logic [3:0]  issue_id_i = 0;
    logic [31:0] issue_addr_i = 0, issue_wdata_i = 0, issue_next_addr_i = 0;
    logic [4:0]  issue_rd_i = 0;
    logic        mem_valid_o, mem_ready_i = 0, mem_we_o, mem_resp_exc_i = 0;
    logic [3:0]  mem_id_o, mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_result_valid_i = 0;
    logic [3:0]  mem_result_id_i = 0;
    logic        ex2wb_valid_o, ex2wb_we_o, exc_o, err_o;
    logic [3:0]  ex2wb_id_o;
    logic [4:0]  ex2wb_rd_o;
    logic [31:0] ex2wb_next_addr_o;

    fir_xifu_mem_req #(.DEPTH(2), .IDW(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_id_i(issue_id_i), .issue_we_i(issue_we_i),
        .issue_addr_i(issue_addr_i), .issue_wdata_i(issue_wdata_i),
        .issue_next_addr_i(issue_next_addr_i), .issue_rd_i(issue_rd_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_id_o(mem_id_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_resp_exc_i(mem_resp_exc_i),
        .mem_result_valid_i(mem_result_valid_i), .mem_result_id_i(mem_result_id_i),
        .ex2wb_valid_o(ex2wb_valid_o), .ex2wb_id_o(ex2wb_id_o), .ex2wb_rd_o(ex2wb_rd_o),
        .ex2wb_next_addr_o(ex2wb_next_addr_o), .ex2wb_we_o(ex2wb_we_o),
        .exc_o(exc_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic rst, iv; logic [3:0] id; logic we; logic [31:0] addr, wdata, nxt; logic [4:0] rd;
        logic mr, mexc, rv; logic [3:0] rid;
        logic ir, mv; logic [31:0] maddr, mwdata; logic mwe, xv, head; logic [4:0] xrd;
        logic [31:0] xnxt; logic xwe, exc, err;
    } vec_t;

    vec_t tbl[$];
    int n_chk = 0, n_fail = 0, row = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", n, row, a, e);
        end
    endtask

    initial begin
        //         rst iv id we addr     wdata         nxt      rd mr ex rv rid | ir mv maddr   mwdata        mwe xv hd xrd xnxt    xwe exc err
        tbl.push_back('{1,0,0,0,0,       0,            0,       0, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,1,3,0,'h100,   0,            'h104,   5, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 1,0,0,0,   0,1,'h100,  0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,1,3,   1,0,0,      0,            0,1,1,5,'h104,  0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,1,1,1,'h200,   'hDEADBEEF,   'h204,   7, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,0});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{0,0,0,0,0,   0,            0,       0, 0,0,0,0,   0,1,'h200,  'hDEADBEEF,   1,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 1,0,0,0,   0,1,'h200,  'hDEADBEEF,   1,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,1,2,0,'h300,   0,            'h304,   9, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 1,0,0,0,   0,1,'h300,  0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,1,5,0,'h700,   0,            'h704,   4, 0,0,0,0,   0,0,0,      0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,1,1,   0,0,0,      0,            0,1,1,7,'h204,  1,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,0,0,   1,0,0,      0,            0,0,1,9,'h304,  0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,1,2,   1,0,0,      0,            0,1,1,9,'h304,  0,0,0});
        tbl.push_back('{0,1,6,0,'h400,   0,            'h404,   3, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 1,1,0,0,   0,1,'h400,  0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,1,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,1,6,   1,0,0,      0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,1});
        tbl.push_back('{1,0,0,0,0,       0,            0,       0, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,1,0,   1,0,0,      0,            0,0,0,0,0,      0,0,0});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,1});
        tbl.push_back('{0,0,0,0,0,       0,            0,       0, 0,0,0,0,   1,0,0,      0,            0,0,0,0,0,      0,0,1});

        foreach (tbl[k]) begin
            @(negedge clk_i);
            row = k;
            rst_i = tbl[k].rst; issue_valid_i = tbl[k].iv; issue_id_i = tbl[k].id;
            issue_we_i = tbl[k].we; issue_addr_i = tbl[k].addr; issue_wdata_i = tbl[k].wdata;
            issue_next_addr_i = tbl[k].nxt; issue_rd_i = tbl[k].rd; mem_ready_i = tbl[k].mr;
            mem_resp_exc_i = tbl[k].mexc; mem_result_valid_i = tbl[k].rv; mem_result_id_i = tbl[k].rid;
            #1;
            chk("issue_ready", 32'(issue_ready_o), 32'(tbl[k].ir));
            chk("mem_valid", 32'(mem_valid_o), 32'(tbl[k].mv));
            if (tbl[k].mv) begin
                chk("mem_addr", mem_addr_o, tbl[k].maddr);
                chk("mem_wdata", mem_wdata_o, tbl[k].mwdata);
                chk("mem_we", 32'(mem_we_o), 32'(tbl[k].mwe));
                chk("mem_be", 32'(mem_be_o), 32'hF);
            end
            chk("ex2wb_valid", 32'(ex2wb_valid_o), 32'(tbl[k].xv));
            if (tbl[k].head) begin
                chk("ex2wb_rd", 32'(ex2wb_rd_o), 32'(tbl[k].xrd));
                chk("ex2wb_next_addr", ex2wb_next_addr_o, tbl[k].xnxt);
                chk("ex2wb_we", 32'(ex2wb_we_o), 32'(tbl[k].xwe));
            end
            chk("exc", 32'(exc_o), 32'(tbl[k].exc));
            chk("err", 32'(err_o), 32'(tbl[k].err));
        end

        // One entry outstanding plus a second request stalled, then async reset.
        row = 100;
        @(negedge clk_i);
        mem_result_valid_i = 0; issue_valid_i = 1; issue_id_i = 4; issue_we_i = 0;
        issue_addr_i = 'h500; issue_next_addr_i = 'h504; issue_rd_i = 1;
        @(negedge clk_i);
        issue_valid_i = 0; mem_ready_i = 1;
        @(negedge clk_i);
        mem_ready_i = 0; issue_valid_i = 1; issue_id_i = 5; issue_addr_i = 'h600;
        issue_next_addr_i = 'h604; issue_rd_i = 2;
        @(negedge clk_i);
        issue_valid_i = 0;
        #1;
        chk("stall_mem_valid", 32'(mem_valid_o), 32'd1);
        chk("stall_mem_addr", mem_addr_o, 32'h600);
        chk("stall_issue_ready", 32'(issue_ready_o), 32'd0);
        chk("stall_err_sticky", 32'(err_o), 32'd1);
        rst_i = 1;
        #1;
        chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
        chk("rst_issue_ready", 32'(issue_ready_o), 32'd1);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        @(negedge clk_i);
        rst_i = 0;
        @(negedge clk_i);
        row = 101;
        mem_result_valid_i = 1; mem_result_id_i = 4;
        #1;
        chk("post_rst_ex2wb_valid", 32'(ex2wb_valid_o), 32'd0);
        @(negedge clk_i);
        mem_result_valid_i = 0;
        #1;
        chk("post_rst_err", 32'(err_o), 32'd1);
        chk("post_rst_mem_valid", 32'(mem_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
